// File: rtl/hazard_scoreboard_pkg.sv
// hazard_pkg: shared definitions for the hazard scoreboard.
//   FWD_RF        fwd_sel code meaning "operand comes from the register file"
//   AW_MAX/SW_MAX storage widths of the table entry fields
//   entry_t       one in-flight write: valid, destination, cycles until result valid
//   sel_width_ok  checks that an SW-bit fwd_sel can encode 0..NSTAGE
package hazard_pkg;

    localparam int unsigned FWD_RF = 0;
    localparam int unsigned AW_MAX = 8;
    localparam int unsigned SW_MAX = 4;

    typedef struct packed {
        logic              v;
        logic [AW_MAX-1:0] rd;
        logic [SW_MAX-1:0] cnt;
    } entry_t;

    function automatic bit sel_width_ok(input int unsigned nstage, input int unsigned sw);
        return (nstage >= 1) && (sw <= SW_MAX) && (nstage < (32'd1 << sw));
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage / pipeline bus of the hazard scoreboard.
//   master: the core (drives ID fields, flush/hold, stage results, regfile data)
//   slave : the scoreboard (returns resolved operands, fwd_sel, issue/stall, stall_cnt)
interface hazard_scoreboard_if #(
    parameter int unsigned DW     = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NSTAGE = 3,
    parameter int unsigned SW     = 2
);
    logic                   id_valid;
    logic [NRD*AW-1:0]      id_src;
    logic [NRD-1:0]         id_src_use;
    logic [AW-1:0]          id_rd;
    logic                   id_regw;
    logic [SW-1:0]          id_lat;
    logic                   flush;
    logic                   hold;
    logic [NSTAGE*DW-1:0]   stage_res;
    logic [NRD*DW-1:0]      rf_rdata;
    logic [NRD*DW-1:0]      src_data;
    logic [NRD*SW-1:0]      fwd_sel;
    logic                   issue;
    logic                   stall;
    logic [15:0]            stall_cnt;

    modport master (
        output id_valid, id_src, id_src_use, id_rd, id_regw, id_lat,
        output flush, hold, stage_res, rf_rdata,
        input  src_data, fwd_sel, issue, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_src, id_src_use, id_rd, id_regw, id_lat,
        input  flush, hold, stage_res, rf_rdata,
        output src_data, fwd_sel, issue, stall, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard_track_entry.sv
// hazard_track_entry: one scoreboard slot mirroring one post-ID pipeline stage.
//   clk, rst    clock, asynchronous active-low reset (clears the slot)
//   en          advance (pipeline not held); when low the slot keeps its contents
//   in_ent      entry arriving from the younger neighbour (or from ID for slot 0)
//   src/src_use ID source addresses and their use flags
//   ent         current slot contents
//   hit         per-port match: used, non-zero source, slot valid, same register
//   ready       result of this slot is already available for forwarding
module hazard_track_entry
    import hazard_pkg::*;
#(
    parameter int unsigned AW  = 5,
    parameter int unsigned NRD = 2,
    parameter bit          DEC = 1'b1   // slot 0 takes the ID countdown as-is
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  entry_t            in_ent,
    input  logic [NRD*AW-1:0] src,
    input  logic [NRD-1:0]    src_use,
    output entry_t            ent,
    output logic [NRD-1:0]    hit,
    output logic              ready
);

    entry_t ent_q;
    entry_t ent_d;

    always_comb begin
        ent_d = ent_q;
        if (en) begin
            ent_d = in_ent;
            if (DEC && (in_ent.cnt != '0)) begin
                ent_d.cnt = in_ent.cnt - SW_MAX'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    always_comb begin
        hit = '0;
        for (int unsigned p = 0; p < NRD; p++) begin
            hit[p] = src_use[p] && (src[p*AW +: AW] != '0) && ent_q.v &&
                     (ent_q.rd == AW_MAX'(src[p*AW +: AW]));
        end
    end

    assign ready = (ent_q.cnt == '0);
    assign ent   = ent_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes from issue to retirement,
// selects per-operand forwarding sources and stalls ID on unresolved results.
//   clk   clock, rising edge
//   rst   asynchronous reset, active-low
//   bus   hazard_scoreboard_if.slave: ID fields, flush/hold, stage results and
//         regfile data in; src_data, fwd_sel, issue, stall, stall_cnt out
// The interface instance must be built with the same DW/AW/NRD/NSTAGE/SW.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned DW     = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NSTAGE = 3,
    parameter int unsigned SW     = 2
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave bus
);

    if (!sel_width_ok(NSTAGE, SW) || (AW > AW_MAX) || (AW == 0)) begin : g_param_check
        $error("hazard_scoreboard: NSTAGE/SW/AW out of range");
    end

    localparam logic [SW:0] NST_W = (SW+1)'(NSTAGE);

    entry_t            id_ent;
    entry_t            slot  [NSTAGE];
    logic [NRD-1:0]    hit   [NSTAGE];
    logic [NSTAGE-1:0] ready;

    logic [SW-1:0]     lat_c;
    logic [NRD*SW-1:0] fwd_sel;
    logic [NRD*DW-1:0] src_data;
    logic [NRD-1:0]    found;
    logic              hazard;
    logic              stall;
    logic              issue;
    logic              advance;
    logic [15:0]       stall_cnt_q;
    logic [15:0]       stall_cnt_d;

    assign advance = ~bus.hold;

    // Latency is clamped to 1..NSTAGE so every result is produced before retirement.
    always_comb begin
        lat_c = bus.id_lat;
        if (bus.id_lat == '0) begin
            lat_c = SW'(1);
        end else if ({1'b0, bus.id_lat} > NST_W) begin
            lat_c = SW'(NSTAGE);
        end
    end

    // A stalled or flushed ID produces a bubble (v=0) in slot 0.
    always_comb begin
        id_ent     = '0;
        id_ent.v   = issue & bus.id_regw & (bus.id_rd != '0);
        id_ent.rd  = AW_MAX'(bus.id_rd);
        id_ent.cnt = SW_MAX'(lat_c - SW'(1));
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_slot
        entry_t up;
        if (k == 0) begin : g_head
            assign up = id_ent;
        end else begin : g_body
            assign up = slot[k-1];
        end

        hazard_track_entry #(
            .AW  (AW),
            .NRD (NRD),
            .DEC (k != 0)
        ) u_entry (
            .clk     (clk),
            .rst     (rst),
            .en      (advance),
            .in_ent  (up),
            .src     (bus.id_src),
            .src_use (bus.id_src_use),
            .ent     (slot[k]),
            .hit     (hit[k]),
            .ready   (ready[k])
        );
    end

    // Youngest matching slot decides: forward if ready, otherwise hazard.
    always_comb begin
        fwd_sel  = '0;
        src_data = '0;
        found    = '0;
        hazard   = 1'b0;
        for (int unsigned p = 0; p < NRD; p++) begin
            fwd_sel[p*SW +: SW]  = SW'(FWD_RF);
            src_data[p*DW +: DW] = bus.rf_rdata[p*DW +: DW];
            for (int unsigned k = 0; k < NSTAGE; k++) begin
                if (!found[p] && hit[k][p]) begin
                    found[p] = 1'b1;
                    if (ready[k]) begin
                        fwd_sel[p*SW +: SW]  = SW'(k + 1);
                        src_data[p*DW +: DW] = bus.stage_res[k*DW +: DW];
                    end else begin
                        hazard = 1'b1;
                    end
                end
            end
            if (bus.id_src[p*AW +: AW] == '0) begin
                src_data[p*DW +: DW] = '0;
            end
        end
    end

    assign stall = bus.id_valid & hazard;
    assign issue = bus.id_valid & ~stall & ~bus.flush & ~bus.hold;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !bus.flush && !bus.hold && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.src_data  = src_data;
    assign bus.fwd_sel   = fwd_sel;
    assign bus.issue     = issue;
    assign bus.stall     = stall;
    assign bus.stall_cnt = stall_cnt_q;

endmodule
